pll_lock_sequencer: RTL and testbench

// Power-up and recovery sequencer for the iCE40 PLL (12 MHz in, 24 MHz out). Runs on the free-running
// 12 MHz pad clock, drives PLL RESETB/BYPASS, and holds the sniffer's system reset until lock is stable.

---
 rtl/pll_lock_sequencer_pkg.sv | 38 +++
 rtl/pll_lock_sequencer_sync_bit.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encodings, registered-output bundle and sizing helper for the PLL lock sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pll_lock_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAILED    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic resetb;
        logic bypass;
        logic sys_reset;
        logic ready;
        logic failed;
    } seq_out_t;

    localparam seq_out_t OUT_RESET = '{
        resetb:    1'b0,
        bypass:    1'b0,
        sys_reset: 1'b1,
        ready:     1'b0,
        failed:    1'b0
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Single-bit synchroniser: STAGES-deep flop chain, synchronously cleared.
// Latency: STAGES cycles from d to q.
// Backpressure: none.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: drives RESETB/BYPASS and holds sys_reset until lock is stable.
// Latency: outputs registered; pll_locked reaches the FSM after SYNC_STAGES cycles.
// Backpressure: none; restart is a one-cycle pulse honoured in any state.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 240,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             clock_in,
    input  logic                             reset,
    input  logic                             pll_locked,
    input  logic                             restart,
    output logic                             pll_resetb,
    output logic                             pll_bypass,
    output logic                             sys_reset,
    output logic                             pll_ready,
    output logic                             failed,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [7:0]                       lock_loss_count,
    output logic [STATE_W-1:0]               state
);

    localparam int RW    = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

    logic             lock_s;
    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic             enter;
    logic [CNT_W-1:0] cnt_q;
    logic [RW-1:0]    retry_q;
    logic [RW-1:0]    retry_nxt;
    logic [7:0]       loss_q;
    logic [7:0]       loss_nxt;
    seq_out_t         out_q;
    seq_out_t         out_nxt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clock_in),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // State, counters and outputs all move on the same edge so outputs track state exactly.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= ST_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_nxt;
            retry_q <= retry_nxt;
            loss_q  <= loss_nxt;
            out_q   <= out_nxt;
            if (enter) begin
                cnt_q <= '0;
            end else if (state_q == ST_RESET_PLL || state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        loss_nxt  = loss_q;
        enter     = 1'b0;
        if (restart) begin
            // Wins over a coincident timeout or lock loss; that loss is deliberately not counted.
            state_nxt = ST_RESET_PLL;
            retry_nxt = '0;
            enter     = 1'b1;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RESET_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        enter     = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        enter     = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_nxt = retry_q + RW'(1);
                        state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAILED : ST_RESET_PLL;
                        enter     = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        enter     = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                        enter     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_RESET_PLL;
                        loss_nxt  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                        enter     = 1'b1;
                    end
                end
                ST_FAILED: begin
                    state_nxt = ST_FAILED;
                end
                default: begin
                    state_nxt = ST_RESET_PLL;
                    enter     = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_nxt = OUT_RESET;
        case (state_nxt)
            ST_WAIT_LOCK, ST_STABLE: begin
                out_nxt.resetb = 1'b1;
            end
            ST_RUN: begin
                out_nxt.resetb    = 1'b1;
                out_nxt.sys_reset = 1'b0;
                out_nxt.ready     = 1'b1;
            end
            ST_FAILED: begin
                // Bypass mode: system runs off the 12 MHz reference with the PLL held in reset.
                out_nxt.bypass    = 1'b1;
                out_nxt.sys_reset = 1'b0;
                out_nxt.failed    = 1'b1;
            end
            default: begin
                out_nxt = OUT_RESET;
            end
        endcase
    end

    assign pll_resetb      = out_q.resetb;
    assign pll_bypass      = out_q.bypass;
    assign sys_reset       = out_q.sys_reset;
    assign pll_ready       = out_q.ready;
    assign failed          = out_q.failed;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/elapsed-time reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized lock/restart/reset traffic.
module tb_pll_lock_sequencer;

    localparam int RC   = 4;
    localparam int LT   = 20;
    localparam int SC   = 8;
    localparam int MR   = 3;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_reset;
    logic       pll_ready;
    logic       failed;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clock_in        (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_resetb      (pll_resetb),
        .pll_bypass      (pll_bypass),
        .sys_reset       (sys_reset),
        .pll_ready       (pll_ready),
        .failed          (failed),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase number (0 reset-pll, 1 wait, 2 stable, 3 run, 4 failed),
    // cycles elapsed in the phase, and lock as seen SYNC edges late via a sample history.
    int m_phase, m_el, m_retry, m_loss;
    bit m_valid = 1'b0;
    bit hist[$];

    always @(posedge clk) begin : model_b
        bit ls;
        if (reset) begin
            m_phase = 0; m_el = 0; m_retry = 0; m_loss = 0;
            hist.delete();
            m_valid = 1'b1;
        end else begin
            ls = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
            hist.push_front(pll_locked);
            if (hist.size() > SYNC) void'(hist.pop_back());
            if (restart) begin
                m_phase = 0; m_el = 0; m_retry = 0;
            end else if (m_phase == 0) begin
                m_el++;
                if (m_el == RC) begin m_phase = 1; m_el = 0; end
            end else if (m_phase == 1) begin
                if (ls) begin
                    m_phase = 2; m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == LT) begin
                        m_retry++;
                        m_phase = (m_retry == MR) ? 4 : 0;
                        m_el = 0;
                    end
                end
            end else if (m_phase == 2) begin
                if (!ls) begin
                    m_phase = 1; m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == SC) begin m_phase = 3; m_el = 0; m_retry = 0; end
                end
            end else if (m_phase == 3) begin
                if (!ls) begin
                    m_phase = 0; m_el = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", state, m_phase);
            chk("pll_resetb", pll_resetb, (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
            chk("pll_bypass", pll_bypass, (m_phase == 4) ? 1 : 0);
            chk("sys_reset", sys_reset, (m_phase == 3 || m_phase == 4) ? 0 : 1);
            chk("pll_ready", pll_ready, (m_phase == 3) ? 1 : 0);
            chk("failed", failed, (m_phase == 4) ? 1 : 0);
            chk("retry_count", retry_count, m_retry);
            chk("lock_loss_count", lock_loss_count, m_loss);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int n = 0;
        while (int'(state) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, state, st);
    endtask

    task automatic chk_reset_values(input string name);
        logic [17:0] act;
        logic [17:0] exp;
        exp = {3'd0, 5'b00100, 2'd0, 8'd0};
        act = {state, pll_resetb, pll_bypass, sys_reset, pll_ready, failed, retry_count, lock_loss_count};
        chk(name, act, exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lowc, falls;
        bit prev_sr;
        logic [23:0] code;
        logic [2:0] last_st;

        // Clean lock from cycle 10.
        do_reset();
        chk_reset_values("reset_values_initial");
        n = 0; lowc = 0; falls = 0; prev_sr = sys_reset;
        while (!pll_ready && n < 200) begin
            if (n == 10) pll_locked = 1'b1;
            if (!pll_resetb) lowc++;
            @(negedge clk);
            n++;
            if (prev_sr && !sys_reset) falls++;
            prev_sr = sys_reset;
        end
        chk("clean_cycles_to_run", n, 21);
        chk("clean_resetb_low_cycles", lowc, RC);
        repeat (5) begin
            @(negedge clk);
            if (prev_sr && !sys_reset) falls++;
            prev_sr = sys_reset;
        end
        chk("clean_sys_reset_falls", falls, 1);
        chk("clean_pll_ready", pll_ready, 1);
        chk("clean_retry_count", retry_count, 0);

        // Single lock loss in RUN.
        pll_locked = 1'b0;
        n = 0;
        while (!sys_reset && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("loss_to_sys_reset_cycles", n, SYNC + 1);
        chk("loss_count_one", lock_loss_count, 1);
        pll_locked = 1'b1;
        wait_state(3, 100, "relock_reaches_run");

        // Restart coincident with the cycle lock loss is first seen.
        pll_locked = 1'b0;
        repeat (SYNC) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("prio_state", state, 0);
        chk("prio_loss_unchanged", lock_loss_count, 1);
        pll_locked = 1'b1;
        wait_state(3, 100, "prio_relock_run");

        // Glitchy lock: 5 high, 1 low, then high.
        pll_locked = 1'b0;
        do_reset();
        n = 0; code = 24'h0; last_st = state;
        while (!pll_ready && n < 80) begin
            pll_locked = (n >= 6 && n <= 10) || (n >= 12);
            @(negedge clk);
            n++;
            if (state != last_st) begin
                code = (code << 4) | 24'(state);
                last_st = state;
            end
        end
        chk("glitch_state_trace", code, 24'h12123);
        chk("glitch_retry_count", retry_count, 0);

        // 300 lock losses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            @(negedge clk);
            pll_locked = 1'b1;
            wait_state(0, 10, "loss_loop_leave_run");
            wait_state(3, 60, "loss_loop_back_run");
        end
        chk("loss_saturated", lock_loss_count, 255);

        // Reset while in STABLE.
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_state(2, 40, "reach_stable");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("reset_values_from_stable");

        // Never locks: three attempts then FAILED.
        pll_locked = 1'b0;
        do_reset();
        n = 0; lowc = 0;
        while (!failed && n < 200) begin
            if (!pll_resetb) lowc++;
            @(negedge clk);
            n++;
        end
        chk("nolock_cycles_to_failed", n, MR * (RC + LT));
        chk("nolock_resetb_low_cycles", lowc, MR * RC);
        chk("nolock_bypass", pll_bypass, 1);
        chk("nolock_sys_reset", sys_reset, 0);
        chk("nolock_retry_count", retry_count, MR);
        pll_locked = 1'b1;
        repeat (30) @(negedge clk);
        chk("failed_ignores_lock", state, 4);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_state", state, 0);
        chk("restart_bypass", pll_bypass, 0);
        chk("restart_retry", retry_count, 0);
        chk("restart_sys_reset", sys_reset, 1);

        // Reset while in FAILED.
        pll_locked = 1'b0;
        wait_state(4, 200, "reach_failed");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("reset_values_from_failed");

        // Randomized lock segments with occasional restart and reset.
        for (int s = 0; s < 120; s++) begin
            int dur;
            pll_locked = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(1, 40);
            for (int c = 0; c < dur; c++) begin
                restart = ($urandom_range(0, 79) == 0);
                reset   = ($urandom_range(0, 399) == 0);
                @(negedge clk);
            end
        end
        restart = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
